// File: rtl/stamofu_cq_alloc_if.sv
// Handshake bundle between dispatch/commit/restart logic and the stamofu CQ allocator.
// The allocator uses the slave modport; whoever drives requests uses master.
interface stamofu_cq_alloc_if #(
    parameter int LOG_STAMOFU_CQ_ENTRIES = 4
);
    logic                              dispatch_valid;
    logic                              dispatch_ready;
    logic [LOG_STAMOFU_CQ_ENTRIES-1:0] dispatch_cq_index;
    logic                              commit_valid;
    logic [LOG_STAMOFU_CQ_ENTRIES-1:0] commit_cq_index;
    logic                              restart_valid;
    logic [LOG_STAMOFU_CQ_ENTRIES:0]   restart_keep_count;
    logic [LOG_STAMOFU_CQ_ENTRIES:0]   occupancy;
    logic                              empty;

    modport master (
        output dispatch_valid, commit_valid, restart_valid, restart_keep_count,
        input  dispatch_ready, dispatch_cq_index, commit_cq_index, occupancy, empty
    );

    modport slave (
        input  dispatch_valid, commit_valid, restart_valid, restart_keep_count,
        output dispatch_ready, dispatch_cq_index, commit_cq_index, occupancy, empty
    );
endinterface

// File: rtl/stamofu_cq_alloc.sv
// Store/AMO/fence completion queue index allocator: a head/tail ring whose pointers
// carry an extra wrap bit, so full and empty are told apart without a separate count.
module stamofu_cq_alloc #(
    parameter int STAMOFU_CQ_ENTRIES     = 16,
    parameter int LOG_STAMOFU_CQ_ENTRIES = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    stamofu_cq_alloc_if.slave     cq
);
    localparam int PW = LOG_STAMOFU_CQ_ENTRIES + 1;
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t CAPACITY = ptr_t'(STAMOFU_CQ_ENTRIES);
    localparam ptr_t ONE      = ptr_t'(1);

    ptr_t head_reg, head_next;
    ptr_t tail_reg, tail_next;
    ptr_t occ;
    ptr_t keep_sat;
    logic full;
    logic dispatch_fire;
    logic commit_fire;

    always_comb begin
        occ           = tail_reg - head_reg;
        full          = (occ == CAPACITY);
        keep_sat      = (cq.restart_keep_count > occ) ? occ : cq.restart_keep_count;
        commit_fire   = cq.commit_valid && (occ != '0);
        dispatch_fire = cq.dispatch_valid && !full;
        head_next     = head_reg;
        tail_next     = tail_reg;
        if (cq.restart_valid) begin
            // Restart wins over dispatch; a commit only survives if it retires a kept entry.
            tail_next = head_reg + keep_sat;
            if (commit_fire && (keep_sat != '0)) begin
                head_next = head_reg + ONE;
            end
        end else begin
            if (dispatch_fire) begin
                tail_next = tail_reg + ONE;
            end
            if (commit_fire) begin
                head_next = head_reg + ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    // Outputs depend on registered pointers only, so a freed slot is granted a cycle later.
    assign cq.dispatch_ready    = !full;
    assign cq.dispatch_cq_index = tail_reg[LOG_STAMOFU_CQ_ENTRIES-1:0];
    assign cq.commit_cq_index   = head_reg[LOG_STAMOFU_CQ_ENTRIES-1:0];
    assign cq.occupancy         = occ;
    assign cq.empty             = (occ == '0);
endmodule

// File: tb/tb_stamofu_cq_alloc.sv
// Self-checking bench for stamofu_cq_alloc: directed scenarios plus randomized traffic
// checked against an unbounded-integer queue model.
module tb_stamofu_cq_alloc;
    localparam int N = 16;
    localparam int L = 4;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   check_cnt;

    // Model: monotonically increasing allocation/retire counters (never wrap).
    int m_head;
    int m_tail;

    stamofu_cq_alloc_if #(.LOG_STAMOFU_CQ_ENTRIES(L)) cq_if ();

    stamofu_cq_alloc #(
        .STAMOFU_CQ_ENTRIES(N),
        .LOG_STAMOFU_CQ_ENTRIES(L)
    ) dut (
        .CLK (clk),
        .nRST(rst_n),
        .cq  (cq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_occ();
        return m_tail - m_head;
    endfunction

    // Apply one cycle of inputs, advance the model by the queue rules, then step past the edge.
    task automatic step(input logic dv, input logic cv, input logic rv, input int kc);
        int occ_now;
        int k;
        cq_if.dispatch_valid     = dv;
        cq_if.commit_valid       = cv;
        cq_if.restart_valid      = rv;
        cq_if.restart_keep_count = (L+1)'(kc);
        occ_now = m_occ();
        if (rv) begin
            k = (kc > occ_now) ? occ_now : kc;
            if (cv && k > 0) begin
                m_tail = m_head + k;
                m_head = m_head + 1;
            end else begin
                m_tail = m_head + k;
            end
        end else begin
            if (dv && occ_now < N) m_tail = m_tail + 1;
            if (cv && occ_now > 0) m_head = m_head + 1;
        end
        @(posedge clk);
        #1;
        cq_if.dispatch_valid = 1'b0;
        cq_if.commit_valid   = 1'b0;
        cq_if.restart_valid  = 1'b0;
    endtask

    task automatic reset_dut();
        cq_if.dispatch_valid     = 1'b0;
        cq_if.commit_valid       = 1'b0;
        cq_if.restart_valid      = 1'b0;
        cq_if.restart_keep_count = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        m_head = 0;
        m_tail = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        check_cnt++; if (cq_if.dispatch_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", cq_if.dispatch_ready); else pass_cnt++;
        check_cnt++; if (cq_if.dispatch_cq_index !== 4'd0) $display("FAIL reset_didx got %0d want 0", cq_if.dispatch_cq_index); else pass_cnt++;
        check_cnt++; if (cq_if.commit_cq_index !== 4'd0) $display("FAIL reset_cidx got %0d want 0", cq_if.commit_cq_index); else pass_cnt++;
        check_cnt++; if (cq_if.occupancy !== 5'd0) $display("FAIL reset_occ got %0d want 0", cq_if.occupancy); else pass_cnt++;
        check_cnt++; if (cq_if.empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", cq_if.empty); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_fill();
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            check_cnt++;
            if (cq_if.dispatch_ready !== (i < 16)) $display("FAIL fill_ready cyc %0d got %0b want %0b", i, cq_if.dispatch_ready, (i < 16));
            else pass_cnt++;
            if (i < 16) begin
                check_cnt++;
                if (cq_if.dispatch_cq_index !== 4'(i)) $display("FAIL fill_idx cyc %0d got %0d want %0d", i, cq_if.dispatch_cq_index, i);
                else pass_cnt++;
            end
            step(1'b1, 1'b0, 1'b0, 0);
        end
        check_cnt++; if (cq_if.occupancy !== 5'd16) $display("FAIL fill_occ got %0d want 16", cq_if.occupancy); else pass_cnt++;
        check_cnt++; if (cq_if.empty !== 1'b0) $display("FAIL fill_empty got %0b want 0", cq_if.empty); else pass_cnt++;
        $display("test_fill done");
    endtask

    // Expects to start from the full state left by test_fill.
    task automatic test_full_commit();
        check_cnt++; if (cq_if.dispatch_ready !== 1'b0) $display("FAIL fullc_ready_same got %0b want 0", cq_if.dispatch_ready); else pass_cnt++;
        step(1'b1, 1'b1, 1'b0, 0);
        check_cnt++; if (cq_if.occupancy !== 5'd15) $display("FAIL fullc_occ_mid got %0d want 15", cq_if.occupancy); else pass_cnt++;
        check_cnt++; if (cq_if.dispatch_ready !== 1'b1) $display("FAIL fullc_ready_next got %0b want 1", cq_if.dispatch_ready); else pass_cnt++;
        check_cnt++; if (cq_if.dispatch_cq_index !== 4'd0) $display("FAIL fullc_idx got %0d want 0", cq_if.dispatch_cq_index); else pass_cnt++;
        step(1'b1, 1'b0, 1'b0, 0);
        check_cnt++; if (cq_if.occupancy !== 5'd16) $display("FAIL fullc_occ got %0d want 16", cq_if.occupancy); else pass_cnt++;
        check_cnt++; if (cq_if.commit_cq_index !== 4'd1) $display("FAIL fullc_cidx got %0d want 1", cq_if.commit_cq_index); else pass_cnt++;
        $display("test_full_commit done");
    endtask

    task automatic test_back_to_back();
        reset_dut();
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
            check_cnt++;
            if (cq_if.dispatch_cq_index !== 4'((3 + i) % 16)) $display("FAIL b2b_didx cyc %0d got %0d want %0d", i, cq_if.dispatch_cq_index, (3 + i) % 16);
            else pass_cnt++;
            step(1'b1, 1'b1, 1'b0, 0);
            check_cnt++;
            if (cq_if.occupancy !== 5'd3) $display("FAIL b2b_occ cyc %0d got %0d want 3", i, cq_if.occupancy);
            else pass_cnt++;
        end
        check_cnt++; if (cq_if.commit_cq_index !== 4'(40 % 16)) $display("FAIL b2b_cidx got %0d want %0d", cq_if.commit_cq_index, 40 % 16); else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_restart();
        reset_dut();
        repeat (11) step(1'b1, 1'b0, 1'b0, 0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 0);
        check_cnt++; if (cq_if.commit_cq_index !== 4'd5 || cq_if.occupancy !== 5'd6) $display("FAIL rst_setup got head %0d occ %0d want 5 6", cq_if.commit_cq_index, cq_if.occupancy); else pass_cnt++;
        step(1'b1, 1'b0, 1'b1, 2);
        check_cnt++; if (cq_if.dispatch_cq_index !== 4'd7) $display("FAIL restart_tail got %0d want 7", cq_if.dispatch_cq_index); else pass_cnt++;
        check_cnt++; if (cq_if.occupancy !== 5'd2) $display("FAIL restart_occ got %0d want 2", cq_if.occupancy); else pass_cnt++;
        $display("test_restart done");
    endtask

    task automatic test_restart_commit();
        for (int pass = 0; pass < 2; pass++) begin
            reset_dut();
            repeat (14) step(1'b1, 1'b0, 1'b0, 0);
            repeat (14) step(1'b0, 1'b1, 1'b0, 0);
            repeat (4) step(1'b1, 1'b0, 1'b0, 0);
            check_cnt++; if (cq_if.commit_cq_index !== 4'd14 || cq_if.occupancy !== 5'd4) $display("FAIL rc_setup got head %0d occ %0d want 14 4", cq_if.commit_cq_index, cq_if.occupancy); else pass_cnt++;
            if (pass == 0) begin
                step(1'b0, 1'b1, 1'b1, 9);
                check_cnt++; if (cq_if.commit_cq_index !== 4'd15) $display("FAIL rc_head got %0d want 15", cq_if.commit_cq_index); else pass_cnt++;
                check_cnt++; if (cq_if.dispatch_cq_index !== 4'd2) $display("FAIL rc_tail got %0d want 2", cq_if.dispatch_cq_index); else pass_cnt++;
                check_cnt++; if (cq_if.occupancy !== 5'd3) $display("FAIL rc_occ got %0d want 3", cq_if.occupancy); else pass_cnt++;
            end else begin
                step(1'b0, 1'b1, 1'b1, 0);
                check_cnt++; if (cq_if.commit_cq_index !== 4'd14) $display("FAIL rc0_head got %0d want 14", cq_if.commit_cq_index); else pass_cnt++;
                check_cnt++; if (cq_if.dispatch_cq_index !== 4'd14) $display("FAIL rc0_tail got %0d want 14", cq_if.dispatch_cq_index); else pass_cnt++;
                check_cnt++; if (cq_if.empty !== 1'b1) $display("FAIL rc0_empty got %0b want 1", cq_if.empty); else pass_cnt++;
            end
        end
        $display("test_restart_commit done");
    endtask

    task automatic test_async_reset();
        reset_dut();
        repeat (12) step(1'b1, 1'b0, 1'b0, 0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 0);
        check_cnt++; if (cq_if.occupancy !== 5'd9) $display("FAIL ar_setup got %0d want 9", cq_if.occupancy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        check_cnt++; if (cq_if.occupancy !== 5'd0) $display("FAIL ar_occ got %0d want 0", cq_if.occupancy); else pass_cnt++;
        check_cnt++; if (cq_if.empty !== 1'b1 || cq_if.dispatch_ready !== 1'b1) $display("FAIL ar_flags got empty %0b ready %0b want 1 1", cq_if.empty, cq_if.dispatch_ready); else pass_cnt++;
        check_cnt++; if (cq_if.dispatch_cq_index !== 4'd0 || cq_if.commit_cq_index !== 4'd0) $display("FAIL ar_idx got %0d %0d want 0 0", cq_if.dispatch_cq_index, cq_if.commit_cq_index); else pass_cnt++;
        #1;
        rst_n  = 1'b1;
        m_head = 0;
        m_tail = 0;
        step(1'b0, 1'b1, 1'b0, 0);
        check_cnt++; if (cq_if.occupancy !== 5'd0 || cq_if.commit_cq_index !== 4'd0) $display("FAIL ar_commit_empty got occ %0d head %0d want 0 0", cq_if.occupancy, cq_if.commit_cq_index); else pass_cnt++;
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic dv, cv, rv;
        int   kc;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            dv = ($urandom_range(0, 3) != 0);
            cv = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 15) == 0);
            kc = $urandom_range(0, 31);
            step(dv, cv, rv, kc);
            $display("txn %0d dv=%0b cv=%0b rv=%0b kc=%0d occ=%0d head=%0d tail=%0d", i, dv, cv, rv, kc, cq_if.occupancy, cq_if.commit_cq_index, cq_if.dispatch_cq_index);
            check_cnt++;
            if (cq_if.occupancy !== 5'(m_occ()) || cq_if.empty !== (m_occ() == 0) || cq_if.dispatch_ready !== (m_occ() < N))
                $display("FAIL rand_occ txn %0d got occ %0d empty %0b ready %0b want %0d %0b %0b", i, cq_if.occupancy, cq_if.empty, cq_if.dispatch_ready, m_occ(), (m_occ() == 0), (m_occ() < N));
            else pass_cnt++;
            check_cnt++;
            if (cq_if.commit_cq_index !== 4'(m_head % N) || cq_if.dispatch_cq_index !== 4'(m_tail % N))
                $display("FAIL rand_idx txn %0d got head %0d tail %0d want %0d %0d", i, cq_if.commit_cq_index, cq_if.dispatch_cq_index, m_head % N, m_tail % N);
            else pass_cnt++;
        end
        $display("test_random done");
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        m_head    = 0;
        m_tail    = 0;
        rst_n     = 1'b1;
        cq_if.dispatch_valid     = 1'b0;
        cq_if.commit_valid       = 1'b0;
        cq_if.restart_valid      = 1'b0;
        cq_if.restart_keep_count = '0;
        #2;
        test_reset();
        test_fill();
        test_full_commit();
        test_back_to_back();
        test_restart();
        test_restart_commit();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
